// File: rtl/module_hamming_ctrl_if.sv
// Snapshot/result bundle between the sequencing controller and the
// combinational SECDED Hamming(8,4) datapath.
interface module_hamming_ctrl_if;
   logic [3:0] entrada_o;
   logic [7:0] palabra_rx_o;
   logic [3:0] datos_out_i;
   logic [2:0] sindrome_i;
   logic       error_simple_i;
   logic       error_doble_i;
   logic       no_error_i;

   modport master (
      output entrada_o, palabra_rx_o,
      input  datos_out_i, sindrome_i, error_simple_i, error_doble_i, no_error_i
   );

   modport slave (
      input  entrada_o, palabra_rx_o,
      output datos_out_i, sindrome_i, error_simple_i, error_doble_i, no_error_i
   );
endinterface

// File: rtl/module_hamming_ctrl.sv
// Hamming(8,4) sequencing controller: switch sync/debounce, snapshot launch,
// result capture, saturating error counters and 2-digit 7-seg scan.
//
// state  | meaning
// IDLE   | waiting for the synchronized switch vector to differ from last_vec
// SETTLE | vector changed; counting stable cycles, restart on any change
// LOAD   | drive the settled vector to the datapath
// EVAL   | datapath has settled; capture results and bump counters
module module_hamming_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] REFRESH_CYCLES  = 16'd25000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  entrada_i,
    input  logic [7:0]  palabra_rx_i,
    input  logic        select_pos_i,
    module_hamming_ctrl_if.master dp,
    output logic        result_valid,
    output logic [3:0]  led_out,
    output logic        led_ded,
    output logic [3:0]  disp_nibble,
    output logic [1:0]  an,
    output logic [7:0]  single_cnt,
    output logic [7:0]  double_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, LOAD, EVAL} state_t;

    state_t      state_q, state_d;
    logic [12:0] sync_q1, sync_q2;
    logic [11:0] sw_vec, last_vec;
    logic        select_s;
    logic [15:0] stab_cnt;
    logic [15:0] scan_cnt;
    logic        digit;
    logic [3:0]  pos_reg;
    logic        upd_last, clr_stab, inc_stab, do_load, do_eval;

    assign sw_vec   = sync_q2[11:0];
    assign select_s = sync_q2[12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {select_pos_i, entrada_i, palabra_rx_i};
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        upd_last = 1'b0;
        clr_stab = 1'b0;
        inc_stab = 1'b0;
        do_load  = 1'b0;
        do_eval  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sw_vec != last_vec) begin
                    state_d  = SETTLE;
                    upd_last = 1'b1;
                    clr_stab = 1'b1;
                end
            end
            SETTLE: begin
                if (sw_vec != last_vec) begin
                    upd_last = 1'b1;
                    clr_stab = 1'b1;
                end else if (stab_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                    state_d = LOAD;
                end else begin
                    inc_stab = 1'b1;
                end
            end
            LOAD: begin
                do_load = 1'b1;
                state_d = EVAL;
            end
            EVAL: begin
                do_eval = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vec        <= '0;
            stab_cnt        <= '0;
            dp.entrada_o    <= '0;
            dp.palabra_rx_o <= '0;
            led_out         <= '0;
            led_ded         <= 1'b0;
            pos_reg         <= '0;
            result_valid    <= 1'b0;
            single_cnt      <= '0;
            double_cnt      <= '0;
        end else begin
            if (upd_last) last_vec <= sw_vec;
            if (clr_stab)      stab_cnt <= '0;
            else if (inc_stab) stab_cnt <= stab_cnt + 16'd1;
            if (do_load) begin
                dp.entrada_o    <= last_vec[11:8];
                dp.palabra_rx_o <= last_vec[7:0];
            end
            if (do_eval) begin
                led_out      <= dp.datos_out_i;
                led_ded      <= dp.error_doble_i;
                pos_reg      <= dp.error_doble_i ? 4'hF :
                                (dp.no_error_i ? 4'h0 : {1'b0, dp.sindrome_i});
                result_valid <= 1'b1;
                if (dp.error_simple_i && single_cnt != 8'hFF) single_cnt <= single_cnt + 8'd1;
                if (dp.error_doble_i && double_cnt != 8'hFF)  double_cnt <= double_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            digit    <= 1'b0;
        end else if (scan_cnt == REFRESH_CYCLES - 16'd1) begin
            scan_cnt <= '0;
            digit    <= ~digit;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    // Digit mux is combinational off the digit register so an and the nibble move together.
    always_comb begin
        an          = digit ? 2'b01 : 2'b10;
        disp_nibble = '0;
        case ({select_s, digit})
            2'b00:   disp_nibble = led_out;
            2'b01:   disp_nibble = pos_reg;
            2'b10:   disp_nibble = single_cnt[3:0];
            2'b11:   disp_nibble = double_cnt[3:0];
            default: disp_nibble = '0;
        endcase
    end

endmodule

// File: tb/tb_module_hamming_ctrl.sv
// Bench for module_hamming_ctrl: models the SECDED datapath and scoreboards
// each launched evaluation against a reference of the captured results.
module tb_module_hamming_ctrl;

   localparam int DEB = 8;
   localparam int REF = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] entrada_i;
   logic [7:0] palabra_rx_i;
   logic       select_pos_i;
   logic       result_valid;
   logic [3:0] led_out;
   logic       led_ded;
   logic [3:0] disp_nibble;
   logic [1:0] an;
   logic [7:0] single_cnt;
   logic [7:0] double_cnt;

   module_hamming_ctrl_if dp ();

   module_hamming_ctrl #(
      .DEBOUNCE_CYCLES(16'(DEB)),
      .REFRESH_CYCLES (16'(REF))
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .entrada_i   (entrada_i),
      .palabra_rx_i(palabra_rx_i),
      .select_pos_i(select_pos_i),
      .dp          (dp.master),
      .result_valid(result_valid),
      .led_out     (led_out),
      .led_ded     (led_ded),
      .disp_nibble (disp_nibble),
      .an          (an),
      .single_cnt  (single_cnt),
      .double_cnt  (double_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // word layout: bit i (1..7) = Hamming position i, bit 0 = overall parity
   function automatic logic [7:0] enc(input logic [3:0] d);
      logic [7:0] w;
      w = '0;
      w[3] = d[0];
      w[5] = d[1];
      w[6] = d[2];
      w[7] = d[3];
      w[1] = d[0] ^ d[1] ^ d[3];
      w[2] = d[0] ^ d[2] ^ d[3];
      w[4] = d[1] ^ d[2] ^ d[3];
      w[0] = ^w[7:1];
      return w;
   endfunction

   // returns {data[3:0], syndrome[2:0], err_simple, err_doble, no_error}
   function automatic logic [9:0] dp_model(input logic [7:0] w);
      logic [2:0] s;
      logic       par, es, ed, ne;
      logic [7:0] c;
      s = '0;
      for (int i = 1; i < 8; i++) if (w[i]) s = s ^ 3'(i);
      par = ^w;
      ne  = (s == 3'd0) && !par;
      es  = par;
      ed  = (s != 3'd0) && !par;
      c   = w;
      if (es && s != 3'd0) c[s] = ~c[s];
      return {c[7], c[6], c[5], c[3], s, es, ed, ne};
   endfunction

   assign {dp.datos_out_i, dp.sindrome_i, dp.error_simple_i, dp.error_doble_i, dp.no_error_i}
          = dp_model(dp.palabra_rx_o);

   typedef struct {
      logic [3:0] ent;
      logic [7:0] pal;
      logic [3:0] led;
      logic       ded;
      logic [3:0] pos;
      logic [7:0] sc;
      logic [7:0] dc;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] m_led, m_pos;
   logic       m_ded;
   logic [7:0] m_sc, m_dc;
   int         n_chk, n_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      chk("ent_snap", 32'(dp.entrada_o), 32'(e.ent));
      chk("pal_snap", 32'(dp.palabra_rx_o), 32'(e.pal));
      chk("led_out", 32'(led_out), 32'(e.led));
      chk("led_ded", 32'(led_ded), 32'(e.ded));
      chk("single_cnt", 32'(single_cnt), 32'(e.sc));
      chk("double_cnt", 32'(double_cnt), 32'(e.dc));
      chk("result_valid", 32'(result_valid), 32'd1);
   endtask

   task automatic apply(input logic [3:0] d, input logic [7:0] w, input bit first);
      exp_t       e;
      logic [9:0] r;
      logic [7:0] prev_sc;
      @(negedge clk);
      entrada_i    = d;
      palabra_rx_i = w;
      prev_sc = m_sc;
      r = dp_model(w);
      m_led = r[9:6];
      m_ded = r[1];
      m_pos = r[1] ? 4'hF : (r[0] ? 4'h0 : {1'b0, r[5:3]});
      if (r[2] && m_sc != 8'hFF) m_sc = m_sc + 8'd1;
      if (r[1] && m_dc != 8'hFF) m_dc = m_dc + 8'd1;
      e.ent = d; e.pal = w; e.led = m_led; e.ded = m_ded; e.pos = m_pos;
      e.sc = m_sc; e.dc = m_dc;
      sb.push_back(e);
      repeat (DEB + 4) @(posedge clk);
      #1;
      if (first) chk("early_valid", 32'(result_valid), 32'd0);
      chk("early_single", 32'(single_cnt), 32'(prev_sc));
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic disp_check(input string tag, input logic [3:0] exp0, input logic [3:0] exp1);
      int k;
      k = 0;
      while (an != 2'b10 && k < 4 * REF) begin @(posedge clk); #1; k++; end
      chk({tag, "_an0"}, 32'(an), 32'h2);
      chk({tag, "_d0"}, 32'(disp_nibble), 32'(exp0));
      k = 0;
      while (an != 2'b01 && k < 4 * REF) begin @(posedge clk); #1; k++; end
      chk({tag, "_an1"}, 32'(an), 32'h1);
      chk({tag, "_d1"}, 32'(disp_nibble), 32'(exp1));
   endtask

   initial begin
      n_chk = 0; n_bad = 0;
      m_led = '0; m_pos = '0; m_ded = 1'b0; m_sc = '0; m_dc = '0;
      rst_n = 1'b0; entrada_i = '0; palabra_rx_i = '0; select_pos_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", 32'(an), 32'h2);
      chk("rst_disp", 32'(disp_nibble), 32'h0);
      chk("rst_valid", 32'(result_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // idle scan with zero switches
      repeat (REF - 1) @(posedge clk);
      #1 chk("idle_an_a", 32'(an), 32'h2);
      @(posedge clk);
      #1 chk("idle_an_b", 32'(an), 32'h1);
      repeat (REF) @(posedge clk);
      #1 chk("idle_an_c", 32'(an), 32'h2);
      repeat (DEB + 10) @(posedge clk);
      #1;
      chk("idle_valid", 32'(result_valid), 32'h0);
      chk("idle_led", 32'(led_out), 32'h0);

      // clean, single, double, back to clean, other patterns
      apply(4'hA, enc(4'hA), 1'b1);
      chk("clean_pos", 32'(dut.pos_reg), 32'h0);
      apply(4'hA, enc(4'hA) ^ 8'h08, 1'b0);
      chk("single_pos", 32'(dut.pos_reg), 32'h3);
      chk("single_led", 32'(led_out), 32'hA);
      apply(4'hA, enc(4'hA) ^ 8'h06, 1'b0);
      chk("double_pos", 32'(dut.pos_reg), 32'hF);
      apply(4'hA, enc(4'hA), 1'b0);
      chk("clean2_pos", 32'(dut.pos_reg), 32'(m_pos));

      // glitch shorter than the debounce window on a clean word
      @(negedge clk);
      palabra_rx_i = enc(4'hA) ^ 8'h10;
      repeat (3) @(negedge clk);
      palabra_rx_i = enc(4'hA);
      repeat (DEB + 12) @(posedge clk);
      #1;
      chk("glitch_led", 32'(led_out), 32'(m_led));
      chk("glitch_single", 32'(single_cnt), 32'(m_sc));
      chk("glitch_double", 32'(double_cnt), 32'(m_dc));
      chk("glitch_pos", 32'(dut.pos_reg), 32'(m_pos));

      apply(4'h5, enc(4'h5) ^ 8'h01, 1'b0);
      chk("par_pos", 32'(dut.pos_reg), 32'h0);
      apply(4'h3, enc(4'h3) ^ 8'h80, 1'b0);
      chk("p7_pos", 32'(dut.pos_reg), 32'h7);
      chk("p7_led", 32'(led_out), 32'h3);

      // display views
      disp_check("view_res", m_led, m_pos);
      @(negedge clk);
      select_pos_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      disp_check("view_cnt", m_sc[3:0], m_dc[3:0]);
      @(negedge clk);
      select_pos_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // saturation
      for (int i = 0; i < 260; i++)
         apply(4'hA, enc(4'hA) ^ ((i % 2 == 0) ? 8'h08 : 8'h20), 1'b0);
      chk("sat_single", 32'(single_cnt), 32'hFF);

      // asynchronous reset while settling
      @(negedge clk);
      entrada_i = 4'h6;
      palabra_rx_i = enc(4'h6);
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(result_valid), 32'h0);
      chk("arst_single", 32'(single_cnt), 32'h0);
      chk("arst_double", 32'(double_cnt), 32'h0);
      chk("arst_led", 32'(led_out), 32'h0);
      chk("arst_ded", 32'(led_ded), 32'h0);
      chk("arst_an", 32'(an), 32'h2);
      chk("arst_disp", 32'(disp_nibble), 32'h0);
      chk("arst_ent", 32'(dp.entrada_o), 32'h0);
      chk("arst_pal", 32'(dp.palabra_rx_o), 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
